// File: rtl/apb_master_arbiter.sv
// Two-master round-robin APB arbiter driving one target chain.
// Winner's request is registered; a watchdog forces an error completion.
module apb_master_arbiter #(
  parameter int unsigned timeout_cycles = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] apb_request_0__paddr,
  input  logic        apb_request_0__penable,
  input  logic        apb_request_0__psel,
  input  logic        apb_request_0__pwrite,
  input  logic [31:0] apb_request_0__pwdata,
  output logic [31:0] apb_response_0__prdata,
  output logic        apb_response_0__pready,
  output logic        apb_response_0__perr,
  input  logic [31:0] apb_request_1__paddr,
  input  logic        apb_request_1__penable,
  input  logic        apb_request_1__psel,
  input  logic        apb_request_1__pwrite,
  input  logic [31:0] apb_request_1__pwdata,
  output logic [31:0] apb_response_1__prdata,
  output logic        apb_response_1__pready,
  output logic        apb_response_1__perr,
  output logic [31:0] apb_request__paddr,
  output logic        apb_request__penable,
  output logic        apb_request__psel,
  output logic        apb_request__pwrite,
  output logic [31:0] apb_request__pwdata,
  input  logic [31:0] apb_response__prdata,
  input  logic        apb_response__pready,
  input  logic        apb_response__perr,
  output logic        grant,
  output logic        busy,
  output logic        timeout_event
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(timeout_cycles - 1);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;

  logic req0, req1, any_req, win;
  logic done_ok, done_to, done;

  // Master penable carries no arbitration meaning
  logic unused_pen;
  assign unused_pen = apb_request_0__penable ^ apb_request_1__penable;

  assign req0    = apb_request_0__psel;
  assign req1    = apb_request_1__psel;
  assign any_req = req0 | req1;
  assign win     = (req0 && req1) ? ~last_q : req1;

  assign done_ok = (state_q == ACCESS) && apb_response__pready;
  assign done_to = (state_q == ACCESS) && !apb_response__pready
                   && (cnt_q == CNT_LAST);
  assign done    = done_ok | done_to;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    grant_d  = grant_q;
    last_d   = last_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    cnt_d    = 16'd0;
    if (state_q == IDLE && any_req) begin
      grant_d  = win;
      last_d   = win;
      paddr_d  = win ? apb_request_1__paddr  : apb_request_0__paddr;
      pwdata_d = win ? apb_request_1__pwdata : apb_request_0__pwdata;
      pwrite_d = win ? apb_request_1__pwrite : apb_request_0__pwrite;
    end
    if (state_q == ACCESS && !done) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= 16'd0;
      paddr_q  <= 32'd0;
      pwdata_q <= 32'd0;
      pwrite_q <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  // Outputs
  always_comb begin
    apb_request__psel      = (state_q != IDLE);
    apb_request__penable   = (state_q == ACCESS);
    apb_request__paddr     = paddr_q;
    apb_request__pwdata    = pwdata_q;
    apb_request__pwrite    = pwrite_q;
    apb_response_0__prdata = 32'd0;
    apb_response_0__pready = 1'b0;
    apb_response_0__perr   = 1'b0;
    apb_response_1__prdata = 32'd0;
    apb_response_1__pready = 1'b0;
    apb_response_1__perr   = 1'b0;
    grant                  = grant_q;
    busy                   = (state_q != IDLE);
    timeout_event          = done_to;
    if (done) begin
      if (grant_q) begin
        apb_response_1__pready = 1'b1;
        apb_response_1__perr   = done_ok ? apb_response__perr : 1'b1;
        apb_response_1__prdata = done_ok ? apb_response__prdata : 32'd0;
      end else begin
        apb_response_0__pready = 1'b1;
        apb_response_0__perr   = done_ok ? apb_response__perr : 1'b1;
        apb_response_0__prdata = done_ok ? apb_response__prdata : 32'd0;
      end
    end
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-master, one-target APB arbiter. It lets the JTAG-driven APB bridge and a second APB master (CPU or test sequencer) share one APB target chain, such as the timer. It grants one transaction at a time using round-robin, registers the winning request, runs the full setup/access sequence to the target itself, and steers the response back to the winner. A watchdog converts a hung target into an error completion.

## Interface
Parameters:
- timeout_cycles, default 256: maximum access-phase cycles before a forced error completion (2..65535).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- apb_request_0__paddr / __penable / __psel / __pwrite / __pwdata  in  32/1/1/1/32  master 0 (JTAG bridge) request.
- apb_response_0__prdata / __pready / __perr  out  32/1/1  master 0 response.
- apb_request_1__*, apb_response_1__*  same widths  master 1 request and response.
- apb_request__paddr / __penable / __psel / __pwrite / __pwdata  out  32/1/1/1/32  request to the target.
- apb_response__prdata / __pready / __perr  in  32/1/1  target response.
- grant  out  1  index of the current or last granted master.
- busy  out  1  high in SETUP or ACCESS.
- timeout_event  out  1  one-cycle pulse on a forced completion.

## Operation
- State machine: IDLE, SETUP, ACCESS.
- **IDLE**
  - A master requests when its psel=1; penable is ignored for arbitration.
  - If only one master requests, that master is granted.
  - If both request, the master that is not last_grant is granted.
  - On a grant: latch paddr, pwrite and pwdata from the winner into target-side registers; set grant and last_grant; go to SETUP.
- **SETUP**
  - Target psel=1, penable=0.
  - Go to ACCESS unconditionally.
- **ACCESS**
  - Target psel=1, penable=1. Timeout counter increments each cycle.
  - If the target asserts pready: winner's pready=1 for this cycle, with target prdata/perr passed through combinationally. Target psel and penable go 0 next cycle; counter clears; go to IDLE.
  - Else, if the counter reaches timeout_cycles-1: winner's pready=1, perr=1, prdata=0; timeout_event=1; go to IDLE.
- **Response to masters**
  - The non-granted master always sees pready=0, perr=0, prdata=0.
  - The granted master sees pready=0 outside its completion cycle.
  - Masters hold their request stable while pready=0, per APB rules.
- **Protocol violations**
  - If the granted master drops psel mid-transfer, the target transaction still completes. The response is discarded: winner's pready is still pulsed but ignored.
- **Register behaviour**
  - Target paddr, pwrite and pwdata hold their last values in IDLE.
  - The target never sees a request change during SETUP or ACCESS.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (so master 0 wins the first tie), grant=0.
  - Counter 0.
  - All target request outputs 0.
  - All master response outputs 0.
  - busy=0, timeout_event=0.
- Assertion of reset forces target psel and penable to 0 asynchronously, aborting any transaction. No response is given to the aborted master.
- Latency with a zero-wait target: psel seen in IDLE at cycle N; target setup at N+1; target access and master pready at N+2. The next arbitration is at N+3.
- Throughput: one transfer per 3 cycles minimum, plus target wait states.
- A request arriving at the completion cycle is evaluated in the following IDLE cycle.
- The master that just completed may re-request immediately. It loses a tie to the other master.
- The timeout counter is 16 bits and saturation is unreachable. A forced completion occurs exactly timeout_cycles cycles after ACCESS entry.
- The target completing pready on the same cycle as the timeout is a normal completion: target perr and prdata are used, and there is no timeout_event.

## Test plan
- Single write from master 0, paddr=0x10, pwdata=0x1234, zero-wait target:
  - Target psel at +1, penable at +2.
  - apb_response_0__pready=1 at +2.
  - Master 1 sees pready=0 throughout.
- Simultaneous psel from both masters after reset, each issuing 3 reads:
  - Grants alternate 0,1,0,1,0,1.
  - Each prdata is routed only to its owner.
  - busy drops between transfers.
- Target inserts 5 wait states on a read returning 0xDEADBEEF:
  - Master pready=0 for 5 access cycles, then 1 with prdata=0xDEADBEEF.
  - Target request is stable throughout.
- Target never responds, timeout_cycles=4:
  - Winner gets pready=1, perr=1, prdata=0 on the 4th ACCESS cycle.
  - timeout_event pulses once.
  - The next request is then serviced normally.
- Reset asserted during ACCESS:
  - Target psel and penable drop to 0 immediately.
  - All outputs are at reset values.
  - After release, master 0 wins a tie.
- Target returns perr=1 with pready at the timeout cycle: perr=1 is forwarded, no timeout_event.
